alarm_digit_set: RTL and testbench
==================================

// Module: alarm_digit_set
// PURPOSE
//  Stage directly downstream of the alarm digit-select sequencer. Holds the alarm time (HH:MM, BCD).
//  Increments the digit selected by CURRENT_STATE_TIME on each BAP_BTN3 pulse while alarm-set mode is active.
//  Compares the alarm against the running clock and drives ALARM_RING for a bounded number of seconds.
//  Feeds the display mux (ALM_*) and the buzzer driver (ALARM_RING).
// PARAMETERS
//  RING_SEC  60  ring duration, counted in SEC_PULSE pulses (1..63)
//  CNT_W     6   width of the ring counter; 2**CNT_W must be >= RING_SEC
// PORTS
//  CLK                 in   1  system clock; every register is on its rising edge
//  RESET_N             in   1  asynchronous, active-low reset
//  SEL_MODE2           in   1  1 = alarm-set mode active
//  CURRENT_STATE_TIME  in   7  selected digit; codes BASE/HOUR10/HOUR1/MIN10/MIN1 from param.v
//  BAP_BTN3            in   1  one-cycle increment pulse
//  BAP_BTN1            in   1  one-cycle stop-ring pulse
//  ALARM_ON            in   1  alarm enable switch (already synchronised)
//  SEC_PULSE           in   1  one-cycle pulse, once per second
//  TIME_H10,TIME_H1    in   4  running hour, BCD
//  TIME_M10,TIME_M1    in   4  running minute, BCD
//  TIME_S10,TIME_S1    in   4  running second, BCD
//  ALM_H10,ALM_H1      out  4  alarm hour, BCD, registered
//  ALM_M10,ALM_M1      out  4  alarm minute, BCD, registered
//  ALARM_RING          out  1  1 while in RING state, registered
// BEHAVIOUR
//  Reset (RESET_N=0, asynchronous):
//   - ALM_* = 00:00; ALARM_RING=0; state=IDLE; ring count=0; match_q=1.
//   - match_q=1 prevents a spurious ring when the clock already reads 00:00:00 at reset release.
//  Digit increment: a register update occurs only when SEL_MODE2=1 and BAP_BTN3=1. It lands on the next edge.
//   - HOUR10: 0->1->2->0.
//   - HOUR1: 0..9 wrap when ALM_H10<2; 0..3 wrap when ALM_H10=2.
//   - MIN10: 0..5 wrap.  MIN1: 0..9 wrap.
//   - BASE or any other code: no change.
//   - No carry or borrow into neighbouring digits.
//   - When H10 steps 1->2 with ALM_H1>3, ALM_H1 is cleared to 0 on the same edge.
//   - BAP_BTN3 while SEL_MODE2=0 is ignored.
//  Match detection:
//   - match_now = ALARM_ON & ~SEL_MODE2 & (TIME HH:MM == ALM HH:MM) & TIME_S10==0 & TIME_S1==0.
//   - match_q <= match_now every cycle.
//   - trigger = match_now & ~match_q, i.e. a rising edge, so the alarm fires at most once per match.
//  FSM, 2 states:
//   - IDLE -> RING on trigger & ~BAP_BTN1. ALARM_RING rises on the edge after TIME first shows the match (1-cycle latency).
//   - RING -> IDLE on any of: BAP_BTN1; ALARM_ON=0; SEL_MODE2=1; (SEC_PULSE & count==RING_SEC-1).
//   - In RING, count increments on SEC_PULSE. Count is cleared on entry to IDLE and on entry to RING.
//   - Simultaneous trigger and BAP_BTN1: stop wins, stay IDLE.
//   - Simultaneous exit conditions: single transition to IDLE.
//  Interactions:
//   - Entering set mode during RING stops the ring on the next edge.
//   - Alarm digits are still editable in that cycle.
//   - A mid-ring reset forces IDLE immediately.
//  Ring length: exactly RING_SEC SEC_PULSE pulses counted while in RING.
// TESTING
//  1. Reset then release with TIME=00:00:00, ALARM_ON=1 -> ALARM_RING stays 0; ALM_*=00:00.
//  2. SEL_MODE2=1, state HOUR10, 3x BTN3 -> H10 0,1,2,0.
//     Set H1=9, then H10 1->2 -> H1 clears to 0 on the same edge.
//     With H10=2: H1 steps 0..3 then wraps to 0.
//  3. Set alarm to 07:30, SEL_MODE2=0, TIME steps 07:29:59 -> 07:30:00 ->
//     ALARM_RING=1 one cycle later. With RING_SEC=3, it drops after the 3rd SEC_PULSE.
//  4. Ring active, BAP_BTN1 pulse -> ALARM_RING=0 next edge.
//     TIME held at 07:30:00 -> no retrigger.
//  5. Trigger cycle coincides with BAP_BTN1 -> ALARM_RING stays 0.
//     Trigger with ALARM_ON=0 -> no ring.
//  6. Ring active, SEL_MODE2 -> 1 -> ALARM_RING=0 next edge.
//     BTN3 with state MIN1 and ALM_M1=9 -> ALM_M1=0, ALM_M10 unchanged.
//     BTN3 in BASE -> ALM_* unchanged.

Source files
------------

// File: rtl/alarm_digit_set.sv
// Alarm time register (HH:MM, BCD) with per-digit increment editing, and a
// match detector that rings for a bounded number of seconds.
module alarm_digit_set #(
  parameter int          RING_SEC  = 60,
  parameter int          CNT_W     = 6,
  // Digit-select codes produced by the upstream digit-select sequencer
  parameter logic [6:0]  ST_BASE   = 7'b000_0001,
  parameter logic [6:0]  ST_HOUR10 = 7'b000_0010,
  parameter logic [6:0]  ST_HOUR1  = 7'b000_0100,
  parameter logic [6:0]  ST_MIN10  = 7'b000_1000,
  parameter logic [6:0]  ST_MIN1   = 7'b001_0000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SEL_MODE2,
  input  logic [6:0] CURRENT_STATE_TIME,
  input  logic       BAP_BTN3,
  input  logic       BAP_BTN1,
  input  logic       ALARM_ON,
  input  logic       SEC_PULSE,
  input  logic [3:0] TIME_H10,
  input  logic [3:0] TIME_H1,
  input  logic [3:0] TIME_M10,
  input  logic [3:0] TIME_M1,
  input  logic [3:0] TIME_S10,
  input  logic [3:0] TIME_S1,
  output logic [3:0] ALM_H10,
  output logic [3:0] ALM_H1,
  output logic [3:0] ALM_M10,
  output logic [3:0] ALM_M1,
  output logic       ALARM_RING
);

  typedef enum logic {IDLE, RING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RING_SEC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_now, match_q, trigger, stop;

  // Digit editing: each digit wraps on its own, no carry between digits.
  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ALM_H10 <= 4'd0;
      ALM_H1  <= 4'd0;
      ALM_M10 <= 4'd0;
      ALM_M1  <= 4'd0;
    end else if (SEL_MODE2 && BAP_BTN3) begin
      case (CURRENT_STATE_TIME)
        ST_BASE: ;
        ST_HOUR10: begin
          ALM_H10 <= (ALM_H10 >= 4'd2) ? 4'd0 : ALM_H10 + 4'd1;
          // Keep the hour legal when moving into the 20s
          if (ALM_H10 == 4'd1 && ALM_H1 > 4'd3) ALM_H1 <= 4'd0;
        end
        ST_HOUR1: begin
          if (ALM_H10 == 4'd2) ALM_H1 <= (ALM_H1 >= 4'd3) ? 4'd0 : ALM_H1 + 4'd1;
          else                 ALM_H1 <= (ALM_H1 >= 4'd9) ? 4'd0 : ALM_H1 + 4'd1;
        end
        ST_MIN10: ALM_M10 <= (ALM_M10 >= 4'd5) ? 4'd0 : ALM_M10 + 4'd1;
        ST_MIN1:  ALM_M1  <= (ALM_M1  >= 4'd9) ? 4'd0 : ALM_M1  + 4'd1;
        default: ;
      endcase
    end
  end

  assign match_now = ALARM_ON && !SEL_MODE2 &&
                     TIME_H10 == ALM_H10 && TIME_H1 == ALM_H1 &&
                     TIME_M10 == ALM_M10 && TIME_M1 == ALM_M1 &&
                     TIME_S10 == 4'd0 && TIME_S1 == 4'd0;
  assign trigger   = match_now && !match_q;
  assign stop      = BAP_BTN1 || !ALARM_ON || SEL_MODE2 ||
                     (SEC_PULSE && cnt_q == CNT_LAST);

  // match_q resets high so a clock already at 00:00:00 does not ring on release
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_now;
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trigger && !BAP_BTN1) begin
          state_d = RING;
          cnt_d   = '0;
        end
      end
      RING: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (SEC_PULSE) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ALARM_RING = (state_q == RING);

endmodule

// File: tb/tb_alarm_digit_set.sv
// Self-checking bench for alarm_digit_set: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_alarm_digit_set;

  localparam int         RING_SEC = 3;
  localparam int         CNT_W    = 2;
  localparam logic [6:0] C_BASE   = 7'b000_0001;
  localparam logic [6:0] C_H10    = 7'b000_0010;
  localparam logic [6:0] C_H1     = 7'b000_0100;
  localparam logic [6:0] C_M10    = 7'b000_1000;
  localparam logic [6:0] C_M1     = 7'b001_0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel, btn3, btn1, alarm_on, sec_pulse;
  logic [6:0] cur;
  logic [3:0] t_h10, t_h1, t_m10, t_m1, t_s10, t_s1;
  logic [3:0] a_h10, a_h1, a_m10, a_m1;
  logic       ring;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: alarm digits as integers, ring as a flag plus seconds left
  int  m_h10, m_h1, m_m10, m_m1;
  bit  m_prev_match, m_ringing;
  int  m_left;

  alarm_digit_set #(
    .RING_SEC(RING_SEC), .CNT_W(CNT_W),
    .ST_BASE(C_BASE), .ST_HOUR10(C_H10), .ST_HOUR1(C_H1),
    .ST_MIN10(C_M10), .ST_MIN1(C_M1)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .SEL_MODE2(sel), .CURRENT_STATE_TIME(cur),
    .BAP_BTN3(btn3), .BAP_BTN1(btn1), .ALARM_ON(alarm_on), .SEC_PULSE(sec_pulse),
    .TIME_H10(t_h10), .TIME_H1(t_h1), .TIME_M10(t_m10), .TIME_M1(t_m1),
    .TIME_S10(t_s10), .TIME_S1(t_s1),
    .ALM_H10(a_h10), .ALM_H1(a_h1), .ALM_M10(a_m10), .ALM_M1(a_m1),
    .ALARM_RING(ring)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_alarm();
    return {m_h10[3:0], m_h1[3:0], m_m10[3:0], m_m1[3:0]};
  endfunction

  task automatic model_reset();
    m_h10 = 0; m_h1 = 0; m_m10 = 0; m_m1 = 0;
    m_prev_match = 1'b1;
    m_ringing = 1'b0;
    m_left = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge state and inputs
  task automatic model_step();
    int  alarm_min, time_min;
    bit  match, trig;
    alarm_min = (m_h10 * 10 + m_h1) * 60 + m_m10 * 10 + m_m1;
    time_min  = (int'(t_h10) * 10 + int'(t_h1)) * 60 + int'(t_m10) * 10 + int'(t_m1);
    match = alarm_on && !sel && (alarm_min == time_min) && t_s10 == 0 && t_s1 == 0;
    trig  = match && !m_prev_match;
    if (m_ringing) begin
      if (btn1 || !alarm_on || sel) m_ringing = 1'b0;
      else if (sec_pulse) begin
        m_left--;
        if (m_left == 0) m_ringing = 1'b0;
      end
    end else if (trig && !btn1) begin
      m_ringing = 1'b1;
      m_left = RING_SEC;
    end
    m_prev_match = match;
    if (sel && btn3) begin
      if (cur == C_H10) begin
        if (m_h10 == 1 && m_h1 > 3) m_h1 = 0;
        m_h10 = (m_h10 + 1) % 3;
      end else if (cur == C_H1)  m_h1  = (m_h1 + 1) % ((m_h10 == 2) ? 4 : 10);
      else if (cur == C_M10)     m_m10 = (m_m10 + 1) % 6;
      else if (cur == C_M1)      m_m1  = (m_m1 + 1) % 10;
    end
  endtask

  // The single compare process: DUT against model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_alarm", {16'd0, a_h10, a_h1, a_m10, a_m1}, {16'd0, model_alarm()});
      check("model_ring", {31'd0, ring}, {31'd0, m_ringing});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [6:0] code);
    cur = code; btn3 = 1'b1; tick();
    btn3 = 1'b0; tick();
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    t_h10 = 4'(hh / 10); t_h1 = 4'(hh % 10);
    t_m10 = 4'(mm / 10); t_m1 = 4'(mm % 10);
    t_s10 = 4'(ss / 10); t_s1 = 4'(ss % 10);
  endtask

  function automatic logic [15:0] dut_alarm();
    return {a_h10, a_h1, a_m10, a_m1};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles expected fewer", $time / 10);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; btn3 = 1'b0; btn1 = 1'b0; alarm_on = 1'b1;
    sec_pulse = 1'b0; cur = C_BASE;
    set_time(0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // 1: release at 00:00:00 with alarm enabled must not ring
    repeat (3) tick();
    check("reset_ring", {31'd0, ring}, 32'd0);
    check("reset_alarm", {16'd0, dut_alarm()}, 32'h0000);

    // 2: hour-tens wrap, hour-ones clear on 1->2, hour-ones 0..3 in the 20s
    sel = 1'b1;
    press(C_H10); check("h10_1", {28'd0, a_h10}, 32'd1);
    press(C_H10); check("h10_2", {28'd0, a_h10}, 32'd2);
    press(C_H10); check("h10_0", {28'd0, a_h10}, 32'd0);
    repeat (9) press(C_H1);
    check("h1_9", {28'd0, a_h1}, 32'd9);
    press(C_H10); check("h_19", {24'd0, a_h10, a_h1}, 32'h19);
    press(C_H10); check("h_20_clear", {24'd0, a_h10, a_h1}, 32'h20);
    press(C_H1); press(C_H1); press(C_H1);
    check("h1_3", {28'd0, a_h1}, 32'd3);
    press(C_H1); check("h1_wrap", {28'd0, a_h1}, 32'd0);

    // 3: alarm 07:30, ring after match, drops after RING_SEC pulses
    press(C_H10);
    repeat (7) press(C_H1);
    repeat (3) press(C_M10);
    check("alarm_0730", {16'd0, dut_alarm()}, 32'h0730);
    set_time(7, 29, 59);
    sel = 1'b0; tick();
    check("pre_match", {31'd0, ring}, 32'd0);
    set_time(7, 30, 0); tick();
    check("ring_rise", {31'd0, ring}, 32'd1);
    for (int i = 1; i <= RING_SEC; i++) begin
      sec_pulse = 1'b1; tick();
      sec_pulse = 1'b0; tick();
      check($sformatf("ring_after_pulse%0d", i), {31'd0, ring}, (i < RING_SEC) ? 32'd1 : 32'd0);
    end

    // 4: stop button, then no retrigger while time holds
    set_time(7, 30, 1); tick();
    set_time(7, 30, 0); tick();
    check("retrig_ring", {31'd0, ring}, 32'd1);
    btn1 = 1'b1; tick(); btn1 = 1'b0;
    check("btn1_stop", {31'd0, ring}, 32'd0);
    repeat (4) tick();
    check("no_retrig", {31'd0, ring}, 32'd0);

    // 5: stop coincident with trigger, and trigger while disabled
    set_time(7, 30, 1); tick();
    set_time(7, 30, 0); btn1 = 1'b1; tick(); btn1 = 1'b0;
    check("trig_btn1", {31'd0, ring}, 32'd0);
    tick();
    check("trig_btn1_hold", {31'd0, ring}, 32'd0);
    alarm_on = 1'b0;
    set_time(7, 30, 1); tick();
    set_time(7, 30, 0); tick();
    check("alarm_off", {31'd0, ring}, 32'd0);

    // 6: set mode stops the ring while the edit lands; minute-ones wraps alone
    alarm_on = 1'b1;
    set_time(7, 30, 1); tick();
    set_time(7, 30, 0); tick();
    check("ring_again", {31'd0, ring}, 32'd1);
    sel = 1'b1; cur = C_M1; btn3 = 1'b1; tick(); btn3 = 1'b0;
    check("sel_stop", {31'd0, ring}, 32'd0);
    check("edit_in_ring", {16'd0, dut_alarm()}, 32'h0731);
    tick();
    repeat (8) press(C_M1);
    check("m1_9", {16'd0, dut_alarm()}, 32'h0739);
    press(C_M1);
    check("m1_wrap", {16'd0, dut_alarm()}, 32'h0730);
    press(C_BASE);
    press(7'h7f);
    check("base_nochange", {16'd0, dut_alarm()}, 32'h0730);

    // Mid-ring asynchronous reset
    sel = 1'b0;
    set_time(7, 30, 1); tick();
    set_time(7, 30, 0); tick();
    check("ring_pre_rst", {31'd0, ring}, 32'd1);
    #2;
    rst_n = 1'b0; model_reset();
    #1;
    check("async_rst_ring", {31'd0, ring}, 32'd0);
    check("async_rst_alarm", {16'd0, dut_alarm()}, 32'h0000);
    tick(); tick();
    rst_n = 1'b1;

    // Randomized traffic, time biased toward the current alarm setting
    for (int n = 0; n < 3000; n++) begin
      int r;
      sel       = ($urandom_range(0, 7) == 0);
      btn3      = ($urandom_range(0, 2) == 0);
      btn1      = ($urandom_range(0, 19) == 0);
      alarm_on  = ($urandom_range(0, 19) != 0);
      sec_pulse = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 5);
      case (r)
        0: cur = C_BASE;
        1: cur = C_H10;
        2: cur = C_H1;
        3: cur = C_M10;
        4: cur = C_M1;
        default: cur = 7'($urandom);
      endcase
      r = $urandom_range(0, 3);
      if (r <= 1) begin
        set_time(m_h10 * 10 + m_h1, m_m10 * 10 + m_m1, (r == 0) ? 0 : $urandom_range(1, 59));
      end else begin
        int hh;
        hh = $urandom_range(0, 23);
        set_time(hh, $urandom_range(0, 59), $urandom_range(0, 1) * $urandom_range(0, 59));
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
